seq_mul_r4: RTL and testbench
=============================

# seq_mul_r4

Parametrised radix-4 Booth sequential multiply-accumulate unit, successor to the fixed 64-bit start/done shift-add multiplier. It computes R = A·B + C mod 2^(2·WIDTH), with signed or unsigned operands selected per operation. Operands and results move over valid/ready handshakes, so the block can be used directly in the Montgomery datapath pipeline. Latency is fixed and independent of operand values.

## Interface
- WIDTH, 64, operand width; must be even and ≥ 4 (elaboration-time assertion).
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept; high only in IDLE, and low while rst_n is low.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- c  input  2·WIDTH  addend; used only when acc_en = 1.
- signed_mode  input  1  1 = a and b are two's complement; 0 = unsigned.
- acc_en  input  1  1 = add c; 0 = addend is zero.
- out_valid  output  1  result is valid; reset value 0.
- out_ready  input  1  consumer accepts the result.
- r  output  2·WIDTH  result; reset value 0; held stable while out_valid is high.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: in_valid & in_ready at an edge is an accept.
  - a and b are extended to WIDTH+2 bits: sign extension if signed_mode = 1, zero extension otherwise.
  - The extended operands are latched, the iteration counter is cleared, psum ← (acc_en ? c : 0), and the state moves to RUN.
  - a, b, c, signed_mode and acc_en are sampled only at the accept edge.
- RUN: N = WIDTH/2 + 1 iterations, one per cycle.
  - Iteration i recodes the triplet {b[2i+1], b[2i], b[2i−1]}, with b[−1] = 0, into a digit in {0, ±1, ±2}.
  - The term digit·a_ext·4^i is added to psum modulo 2^(2·WIDTH); subtraction is done by two's complement.
  - After the last iteration: r ← psum, out_valid ← 1, state ← DONE.
- DONE: r and out_valid are held until out_valid & out_ready at an edge. That edge clears out_valid and moves the state to IDLE. r keeps its value.
- in_valid is ignored outside IDLE. No accept can take place in RUN or DONE.
- Arithmetic: all sums are 2·WIDTH bits wide and wrap modulo 2^(2·WIDTH).
  - The product of two WIDTH-bit operands fits exactly; overflow of the accumulate wraps silently with no flag.
  - Signed result is the two's-complement product plus c.
- Reset mid-operation (rst_n low in any state) at the next edge:
  - state → IDLE; out_valid → 0; r → 0; psum and counter cleared.
  - The in-flight operation is discarded with no partial output.

## Timing
- Accept at edge k. out_valid is visible after edge k+N. For WIDTH = 64, N = 33.
- out_ready may already be high when out_valid rises. The handshake then completes at edge k+N+1, and in_ready is high after that edge.
- The earliest next accept is edge k+N+2. Sustained throughput is one operation per N+2 cycles.
- in_ready is a decode of state. It has no combinational path from in_valid or out_ready.
- out_valid and r are registered outputs.

## Structure
- Package seq_mul_pkg:
  - state enum {IDLE, RUN, DONE}.
  - booth_digit_t: a 3-bit encoding of {0, +1, +2, −1, −2}.
  - Helper function computing the iteration count from WIDTH.
- Sub-module booth_r4_enc: combinational recoder from a 3-bit triplet to booth_digit_t, plus a partial-product selector producing ±a_ext, ±2·a_ext or 0 at 2·WIDTH bits. It is instantiated once.
- Top level holds the FSM, counter, operand and psum registers, and the output register.

## Test plan
- Unsigned max, WIDTH = 64: a = b = 0xFFFF_FFFF_FFFF_FFFF, acc_en = 0 → r = 0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, with out_valid exactly 33 cycles after accept.
- Signed corners, WIDTH = 64:
  - −1 × −1 → r = 1.
  - 0x8000_0000_0000_0000 × 0x8000_0000_0000_0000 → r = 2^126.
  - −3 × 5 → r = 2^128 − 15.
- Accumulate, WIDTH = 8: a = 3, b = 5, c = 7 → r = 22. Then a = b = 0xFF, c = 0xFFFF, unsigned → r = 0xFE00, the wrapped sum.
- Backpressure: hold out_ready low for 10 cycles after out_valid rises → r stable, out_valid high, in_ready low, in_valid pulses ignored. Raise out_ready → in_ready high on the following cycle.
- Reset mid-RUN: drive rst_n low for 1 cycle, 10 cycles after accept → out_valid stays 0 and r = 0. The next operation 7 × 9 returns 63.
- Randomised sweep: 1000 operations per WIDTH ∈ {4, 8, 64}, with random mode, acc_en and out_ready → each r matches a reference model, and the accept-to-valid latency equals WIDTH/2 + 1.

Source files
------------

// File: rtl/seq_mul_r4_pkg.sv
// seq_mul_pkg: shared types and sizing helper for the radix-4 Booth multiply-accumulate unit
package seq_mul_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef enum logic [2:0] {
        BD_ZERO = 3'd0,
        BD_P1   = 3'd1,
        BD_P2   = 3'd2,
        BD_M1   = 3'd3,
        BD_M2   = 3'd4
    } booth_digit_t;

    // One radix-4 digit per bit pair, plus one for the extension bits of b
    function automatic int booth_iters(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/seq_mul_r4_enc.sv
// booth_r4_enc: radix-4 Booth recoder and partial-product selector
module booth_r4_enc
    import seq_mul_pkg::*;
#(
    parameter int PW = 128
) (
    input  logic [2:0]    trip,
    input  logic [PW-1:0] a_sh,
    output logic [PW-1:0] pp
);

    booth_digit_t digit;
    logic [PW-1:0] mag;

    always_comb begin
        digit = (trip == 3'b000 || trip == 3'b111) ? BD_ZERO :
                (trip == 3'b011) ? BD_P2 :
                (trip == 3'b100) ? BD_M2 :
                trip[2] ? BD_M1 : BD_P1;
        mag = (digit == BD_P2 || digit == BD_M2) ? a_sh << 1 : a_sh;
        pp = (digit == BD_ZERO) ? '0 :
             (digit == BD_M1 || digit == BD_M2) ? -mag : mag;
    end

endmodule

// File: rtl/seq_mul_r4.sv
// seq_mul_r4: sequential radix-4 Booth multiply-accumulate, r = a*b + c mod 2^(2*WIDTH)
module seq_mul_r4
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0] c,
    input  logic               signed_mode,
    input  logic               acc_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] r
);

    localparam int PW = 2 * WIDTH;
    localparam int N  = booth_iters(WIDTH);
    localparam int CW = $clog2(N + 1);

    if (WIDTH < 4 || WIDTH % 2 != 0) begin : g_width_check
        $error("seq_mul_r4: WIDTH must be even and >= 4");
    end

    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [PW-1:0] a_sh, psum, pp;
    logic [WIDTH+2:0] b_sh;
    logic last, accept;

    // a_sh holds a_ext * 4^i; b_sh keeps the next triplet in its low 3 bits
    booth_r4_enc #(.PW(PW)) u_enc (
        .trip (b_sh[2:0]),
        .a_sh (a_sh),
        .pp   (pp)
    );

    always_ff @(posedge clk) begin
        state <= !rst_n ? IDLE : state_nx;
    end

    always_comb begin
        state_nx = (state == IDLE) ? (in_valid ? RUN : IDLE) :
                   (state == RUN)  ? (last ? DONE : RUN) :
                   (out_ready ? IDLE : DONE);
    end

    always_comb begin
        in_ready = (state == IDLE) && rst_n;
        accept   = in_valid && in_ready;
        last     = (state == RUN) && (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            psum      <= '0;
            r         <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                a_sh <= {{WIDTH{signed_mode & a[WIDTH-1]}}, a};
                b_sh <= {{2{signed_mode & b[WIDTH-1]}}, b, 1'b0};
                psum <= acc_en ? c : '0;
                cnt  <= '0;
            end
            if (state == RUN) begin
                psum <= psum + pp;
                a_sh <= a_sh << 2;
                b_sh <= b_sh >> 2;
                cnt  <= cnt + CW'(1);
            end
            if (last) begin
                r         <= psum + pp;
                out_valid <= 1'b1;
            end
            if (state == DONE && out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_mul_r4.sv
// tb_seq_mul_r4: randomized and directed checks of seq_mul_r4 at WIDTH 4, 8 and 64
module tb_seq_mul_r4;

    typedef struct {
        int           w;
        logic [127:0] a, b, c;
        bit           sm, acc;
        logic [127:0] exp;
    } vec_t;

    localparam int NV = 10;

    logic clk;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[NV];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input bit act, input bit exp);
        chk(nm, 128'(act), 128'(exp));
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        vecs[0] = '{64, 128'hFFFF_FFFF_FFFF_FFFF, 128'hFFFF_FFFF_FFFF_FFFF, 128'h0, 1'b0, 1'b0,
                    128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
        vecs[1] = '{64, 128'hFFFF_FFFF_FFFF_FFFF, 128'hFFFF_FFFF_FFFF_FFFF, 128'h0, 1'b1, 1'b0, 128'h1};
        vecs[2] = '{64, 128'h8000_0000_0000_0000, 128'h8000_0000_0000_0000, 128'h0, 1'b1, 1'b0,
                    128'h4000_0000_0000_0000_0000_0000_0000_0000};
        vecs[3] = '{64, 128'hFFFF_FFFF_FFFF_FFFD, 128'h5, 128'h0, 1'b1, 1'b0,
                    128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1};
        vecs[4] = '{64, 128'hFFFF_FFFF_FFFF_FFFF, 128'h1, 128'h5, 1'b1, 1'b1, 128'h4};
        vecs[5] = '{8, 128'h3, 128'h5, 128'h7, 1'b0, 1'b1, 128'd22};
        vecs[6] = '{8, 128'hFF, 128'hFF, 128'hFFFF, 1'b0, 1'b1, 128'hFE00};
        vecs[7] = '{4, 128'h8, 128'h8, 128'h0, 1'b1, 1'b0, 128'h40};
        vecs[8] = '{4, 128'hF, 128'hF, 128'h0, 1'b0, 1'b0, 128'hE1};
        vecs[9] = '{4, 128'h7, 128'hF, 128'h10, 1'b1, 1'b1, 128'h9};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 3; g++) begin : gw
        localparam int W  = (g == 0) ? 4 : (g == 1) ? 8 : 64;
        localparam int PW = 2 * W;
        localparam int N  = W / 2 + 1;

        logic rst_n, in_valid, in_ready, out_valid, out_ready, signed_mode, acc_en;
        logic [W-1:0] a, b;
        logic [PW-1:0] c, r, exp_r;
        int ed = 0;
        int acc_edge = 0;
        bit pending = 0;
        bit prev_ov = 0;
        bit fin = 0;

        seq_mul_r4 #(.WIDTH(W)) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid    (in_valid),
            .in_ready    (in_ready),
            .a           (a),
            .b           (b),
            .c           (c),
            .signed_mode (signed_mode),
            .acc_en      (acc_en),
            .out_valid   (out_valid),
            .out_ready   (out_ready),
            .r           (r)
        );

        // Reference: plain wide integer arithmetic, truncated to 2*W bits
        function automatic logic [PW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                                input logic [PW-1:0] mc, input bit sm, input bit acc);
            logic [PW-1:0] x, y;
            x = sm ? PW'($signed(ma)) : PW'(ma);
            y = sm ? PW'($signed(mb)) : PW'(mb);
            return x * y + (acc ? mc : '0);
        endfunction

        always @(posedge clk) ed <= ed + 1;

        always @(negedge clk) begin
            if (!rst_n) begin
                chkb($sformatf("w%0d in_ready in reset", W), in_ready, 1'b0);
                pending <= 1'b0;
            end else begin
                if (out_valid) begin
                    chkb($sformatf("w%0d result owed", W), pending, 1'b1);
                    chk($sformatf("w%0d r", W), 128'(r), 128'(exp_r));
                    chkb($sformatf("w%0d in_ready in DONE", W), in_ready, 1'b0);
                    if (!prev_ov) chk($sformatf("w%0d latency", W), 128'(ed - acc_edge), 128'(N));
                    if (out_ready) pending <= 1'b0;
                end
                if (in_valid && in_ready) begin
                    exp_r    <= model(a, b, c, signed_mode, acc_en);
                    pending  <= 1'b1;
                    acc_edge <= ed + 1;
                end
            end
            prev_ov <= out_valid;
        end

        task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic [PW-1:0] tc,
                              input bit sm, input bit acc, input bit rnd, input int hold);
            int t = 0;
            int held = 0;
            bit hs = 0;
            logic [127:0] j;
            while (!in_ready && t < 10) begin
                @(posedge clk); #1;
                t++;
            end
            a = ta; b = tbv; c = tc; signed_mode = sm; acc_en = acc; in_valid = 1'b1;
            @(posedge clk); #1;
            t = 0;
            while (t < N + 40) begin
                j = rnd128();
                a = j[W-1:0]; b = j[127:128-W]; c = j[PW-1:0];
                signed_mode = j[64]; acc_en = j[65]; in_valid = j[66];
                if (hold > 0) begin
                    out_ready = out_valid && held >= hold;
                    if (out_valid) held++;
                end else out_ready = rnd ? j[67] : 1'b1;
                hs = out_valid && out_ready;
                @(posedge clk); #1;
                t++;
                if (hs) break;
            end
            in_valid = 1'b0;
            out_ready = 1'b0;
            chkb($sformatf("w%0d handshake", W), hs, 1'b1);
            chkb($sformatf("w%0d in_ready after handshake", W), in_ready, 1'b1);
            chkb($sformatf("w%0d out_valid cleared", W), out_valid, 1'b0);
        endtask

        initial begin
            logic [127:0] j1, j2;
            int k;
            rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
            a = '0; b = '0; c = '0; signed_mode = 1'b0; acc_en = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chkb($sformatf("w%0d reset out_valid", W), out_valid, 1'b0);
            chk($sformatf("w%0d reset r", W), 128'(r), 128'h0);
            rst_n = 1'b1;
            for (int i = 0; i < NV; i++) begin
                if (vecs[i].w == W) begin
                    chk($sformatf("w%0d model vec%0d", W, i),
                        128'(model(vecs[i].a[W-1:0], vecs[i].b[W-1:0], vecs[i].c[PW-1:0], vecs[i].sm, vecs[i].acc)),
                        vecs[i].exp);
                    run_op(vecs[i].a[W-1:0], vecs[i].b[W-1:0], vecs[i].c[PW-1:0], vecs[i].sm, vecs[i].acc, 1'b0, 0);
                    chk($sformatf("w%0d dut vec%0d", W, i), 128'(r), vecs[i].exp);
                end
            end
            j1 = rnd128();
            j2 = rnd128();
            run_op(j1[W-1:0], j1[127:128-W], j2[PW-1:0], j2[127], j2[126], 1'b0, 10);
            // Reset while RUN is still in progress
            k = (N - 1 < 10) ? N - 1 : 10;
            j1 = rnd128();
            a = j1[W-1:0]; b = j1[127:128-W]; c = '0; signed_mode = 1'b0; acc_en = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (k - 1) @(posedge clk);
            #1;
            rst_n = 1'b0;
            @(posedge clk); #1;
            chkb($sformatf("w%0d mid reset out_valid", W), out_valid, 1'b0);
            chk($sformatf("w%0d mid reset r", W), 128'(r), 128'h0);
            rst_n = 1'b1;
            repeat (N + 2) begin
                @(posedge clk); #1;
                chkb($sformatf("w%0d no output after reset", W), out_valid, 1'b0);
            end
            run_op(W'(7), W'(9), '0, 1'b0, 1'b0, 1'b0, 0);
            chk($sformatf("w%0d 7x9 after reset", W), 128'(r), 128'd63);
            for (int i = 0; i < 1000; i++) begin
                j1 = rnd128();
                j2 = rnd128();
                run_op(j1[W-1:0], j1[127:128-W], j2[PW-1:0], j2[127], j2[126], 1'b1, 0);
            end
            fin = 1'b1;
        end
    end

    initial begin
        wait (gw[0].fin && gw[1].fin && gw[2].fin);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
